// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: shared state encoding and default timing constants for the clock sequencer.
package clk_seq_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, LOCK, APPLY, DWAIT, SWITCH, REL} state_e;
  localparam int SETTLE_DEF  = 8;
  localparam int LOCK_TO_DEF = 1024;
endpackage

// File: rtl/caravel_clock_sequencer_sync2.sv
// sync2: two-flop synchroniser with async active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/caravel_clock_sequencer.sv
// caravel_clock_sequencer: glitch-safe reconfiguration of the core/user clock generator.
// Parks the mux on ext_clk and holds the core in reset while the PLL or dividers change.
module caravel_clock_sequencer
  import clk_seq_pkg::*;
#(
  parameter int         SETTLE_CYC   = SETTLE_DEF,
  parameter int         LOCK_TIMEOUT = LOCK_TO_DEF,
  parameter logic [2:0] RST_SEL      = 3'd1,
  parameter logic [2:0] RST_SEL2     = 3'd1
) (
  input  logic       ext_clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_use_pll,
  input  logic [2:0] cfg_sel,
  input  logic [2:0] cfg_sel2,
  input  logic       pll_lock,
  output logic       pll_ena,
  output logic       ext_clk_sel,
  output logic [2:0] sel,
  output logic [2:0] sel2,
  output logic       ext_reset,
  output logic       done,
  output logic       err
);
  localparam int MAXC = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic use_pll_q, use_pll_d;
  logic [2:0] sh_sel_q, sh_sel_d, sh_sel2_q, sh_sel2_d;
  logic pll_ena_q, pll_ena_d, ext_clk_sel_q, ext_clk_sel_d;
  logic [2:0] sel_q, sel_d, sel2_q, sel2_d;
  logic ext_reset_q, ext_reset_d, done_q, done_d, err_q, err_d;
  logic lock_s, cnt_zero, accept;
  sync2 u_lock_sync (
    .clk(ext_clk),
    .rst(reset),
    .d  (pll_lock),
    .q  (lock_s)
  );
  assign cfg_ready   = (state_q == IDLE);
  assign accept      = cfg_valid & cfg_ready;
  assign cnt_zero    = (cnt_q == '0);
  assign pll_ena     = pll_ena_q;
  assign ext_clk_sel = ext_clk_sel_q;
  assign sel         = sel_q;
  assign sel2        = sel2_q;
  assign ext_reset   = ext_reset_q;
  assign done        = done_q;
  assign err         = err_q;
  // Every output edge is timed so that ext_reset is already high on both sides of a mux/divider change.
  always_comb begin
    state_d       = state_q;
    use_pll_d     = use_pll_q;
    sh_sel_d      = sh_sel_q;
    sh_sel2_d     = sh_sel2_q;
    pll_ena_d     = pll_ena_q;
    ext_clk_sel_d = ext_clk_sel_q;
    sel_d         = sel_q;
    sel2_d        = sel2_q;
    ext_reset_d   = ext_reset_q;
    done_d        = 1'b0;
    err_d         = err_q;
    cnt_d         = cnt_zero ? '0 : cnt_q - CW'(1);
    case (state_q)
      IDLE: if (accept) begin
        state_d     = HOLD;
        use_pll_d   = cfg_use_pll;
        sh_sel_d    = cfg_sel;
        sh_sel2_d   = cfg_sel2;
        err_d       = 1'b0;
        ext_reset_d = 1'b1;
      end
      HOLD: begin
        ext_clk_sel_d = 1'b1;
        if (cnt_zero) begin
          state_d   = use_pll_q ? LOCK : APPLY;
          pll_ena_d = pll_ena_q | use_pll_q;
        end
      end
      LOCK: if (lock_s) state_d = APPLY;
      else if (cnt_zero) begin
        state_d     = REL;
        pll_ena_d   = 1'b0;
        err_d       = 1'b1;
        ext_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      APPLY: begin
        sel_d   = sh_sel_q;
        sel2_d  = sh_sel2_q;
        state_d = DWAIT;
      end
      DWAIT: state_d = cnt_zero ? SWITCH : DWAIT;
      SWITCH: begin
        ext_clk_sel_d = ~use_pll_q;
        pll_ena_d     = pll_ena_q & use_pll_q;
        if (cnt_zero) begin
          state_d     = REL;
          ext_reset_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q)
      cnt_d = (state_d == LOCK) ? TO_LD :
              (state_d == HOLD || state_d == DWAIT || state_d == SWITCH) ? SET_LD : '0;
  end
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      use_pll_q     <= 1'b0;
      sh_sel_q      <= RST_SEL;
      sh_sel2_q     <= RST_SEL2;
      pll_ena_q     <= 1'b0;
      ext_clk_sel_q <= 1'b1;
      sel_q         <= RST_SEL;
      sel2_q        <= RST_SEL2;
      ext_reset_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      use_pll_q     <= use_pll_d;
      sh_sel_q      <= sh_sel_d;
      sh_sel2_q     <= sh_sel2_d;
      pll_ena_q     <= pll_ena_d;
      ext_clk_sel_q <= ext_clk_sel_d;
      sel_q         <= sel_d;
      sel2_q        <= sel2_d;
      ext_reset_q   <= ext_reset_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end
endmodule

// File: tb/tb_caravel_clock_sequencer.sv
// tb_caravel_clock_sequencer: directed checks of the clock reconfiguration sequence.
module tb_caravel_clock_sequencer;
  logic ext_clk = 1'b0, reset = 1'b1;
  logic cfg_valid = 1'b0, cfg_use_pll = 1'b0, pll_lock = 1'b0;
  logic [2:0] cfg_sel = 3'd0, cfg_sel2 = 3'd0;
  logic cfg_ready, pll_ena, ext_clk_sel, ext_reset, done, err;
  logic [2:0] sel, sel2;
  int vectors = 0, miss = 0;
  logic mon_en = 1'b0;
  logic [2:0] p_sel = 3'd1, p_sel2 = 3'd1;
  logic p_ecs = 1'b1, p_rst = 1'b0;
  caravel_clock_sequencer dut (
    .ext_clk    (ext_clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_use_pll(cfg_use_pll),
    .cfg_sel    (cfg_sel),
    .cfg_sel2   (cfg_sel2),
    .pll_lock   (pll_lock),
    .pll_ena    (pll_ena),
    .ext_clk_sel(ext_clk_sel),
    .sel        (sel),
    .sel2       (sel2),
    .ext_reset  (ext_reset),
    .done       (done),
    .err        (err)
  );
  always #5 ext_clk = ~ext_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge ext_clk);
    #1;
  endtask
  task automatic req(input logic up, input logic [2:0] s, input logic [2:0] s2);
    cfg_use_pll = up;
    cfg_sel     = s;
    cfg_sel2    = s2;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask
  // Mux/divider outputs may only move while ext_reset is high before and after the edge.
  always @(negedge ext_clk) begin
    if (mon_en && !reset) begin
      vectors++;
      assert (!((sel !== p_sel || sel2 !== p_sel2 || ext_clk_sel !== p_ecs) && !(ext_reset && p_rst))) else begin
        miss++;
        $error("FAIL glitch_guard: sel %0d->%0d sel2 %0d->%0d ecs %0b->%0b ext_reset %0b->%0b required high",
               p_sel, sel, p_sel2, sel2, p_ecs, ext_clk_sel, p_rst, ext_reset);
      end
    end
    p_sel  = sel;
    p_sel2 = sel2;
    p_ecs  = ext_clk_sel;
    p_rst  = ext_reset;
  end
  initial begin
    int n;
    logic seen;
    tick();
    chk("rst_ecs", ext_clk_sel, 1);
    chk("rst_pll_ena", pll_ena, 0);
    @(negedge ext_clk);
    reset = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    chk("idle_ecs", ext_clk_sel, 1);
    chk("idle_pll_ena", pll_ena, 0);
    chk("idle_sel", sel, 1);
    chk("idle_sel2", sel2, 1);
    chk("idle_ready", cfg_ready, 1);
    chk("idle_ext_reset", ext_reset, 0);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    req(1'b1, 3'd2, 3'd3);
    chk("t2_ready_low", cfg_ready, 0);
    chk("t2_hold_reset", ext_reset, 1);
    n = 0;
    seen = 1'b0;
    while (done !== 1'b1 && n < 3000) begin
      if (n == 20) pll_lock = 1'b1;
      if (sel == 3'd2 && sel2 == 3'd3 && ext_clk_sel && ext_reset) seen = 1'b1;
      tick();
      n++;
    end
    chk("t2_done", done, 1);
    chk("t2_parked_apply", seen, 1);
    chk("t2_ecs", ext_clk_sel, 0);
    chk("t2_pll_ena", pll_ena, 1);
    chk("t2_sel", sel, 2);
    chk("t2_sel2", sel2, 3);
    chk("t2_ext_reset", ext_reset, 0);
    chk("t2_err", err, 0);
    tick();
    chk("t2_done_pulse", done, 0);
    chk("t2_ready_back", cfg_ready, 1);
    pll_lock = 1'b0;
    repeat (3) tick();
    req(1'b1, 3'd6, 3'd6);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (n == 100) chk("t3_pll_ena_wait", pll_ena, 1);
      tick();
      n++;
    end
    chk("t3_done", done, 1);
    chk("t3_latency_ok", (n >= 1032 && n <= 1036), 1);
    chk("t3_err", err, 1);
    chk("t3_pll_ena", pll_ena, 0);
    chk("t3_ecs", ext_clk_sel, 1);
    chk("t3_sel", sel, 2);
    chk("t3_sel2", sel2, 3);
    chk("t3_ext_reset", ext_reset, 0);
    tick();
    chk("t3_err_sticky", err, 1);
    pll_lock = 1'b1;
    repeat (3) tick();
    req(1'b1, 3'd2, 3'd3);
    chk("t2b_err_cleared", err, 0);
    wait_done(n);
    chk("t2b_latency", n, 26);
    chk("t2b_ecs", ext_clk_sel, 0);
    chk("t2b_err", err, 0);
    tick();
    req(1'b0, 3'd4, 3'd0);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (n == 3) begin
        chk("t4_parked_first", ext_clk_sel, 1);
        chk("t4_ready_busy", cfg_ready, 0);
        cfg_use_pll = 1'b1;
        cfg_sel     = 3'd7;
        cfg_sel2    = 3'd7;
        cfg_valid   = 1'b1;
      end
      if (n == 6) cfg_valid = 1'b0;
      tick();
      n++;
    end
    chk("t4_latency", n, 25);
    chk("t4_sel", sel, 4);
    chk("t4_sel2", sel2, 0);
    chk("t4_ecs", ext_clk_sel, 1);
    chk("t4_pll_ena", pll_ena, 0);
    chk("t4_err", err, 0);
    tick();
    chk("t4_no_reaccept", cfg_ready, 1);
    req(1'b0, 3'd5, 3'd6);
    repeat (12) tick();
    chk("t5_applied", sel, 5);
    chk("t5_in_reset", ext_reset, 1);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_ecs", ext_clk_sel, 1);
    chk("t5_pll_ena", pll_ena, 0);
    chk("t5_sel", sel, 1);
    chk("t5_sel2", sel2, 1);
    chk("t5_ext_reset", ext_reset, 0);
    chk("t5_ready", cfg_ready, 1);
    chk("t5_err", err, 0);
    @(negedge ext_clk);
    reset = 1'b0;
    @(negedge ext_clk);
    mon_en = 1'b1;
    repeat (3) tick();
    req(1'b1, 3'd6, 3'd7);
    wait_done(n);
    chk("t5_rerun_latency", n, 26);
    chk("t5_rerun_sel", sel, 6);
    chk("t5_rerun_sel2", sel2, 7);
    chk("t5_rerun_ecs", ext_clk_sel, 0);
    chk("t5_rerun_err", err, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
